// File: rtl/ALU_REGFILE_defs.sv
// Shared opcode encoding and default sizing for the pipelined ALU/register-file block.
package ALU_REGFILE_defs;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int REG_DEPTH_DEF  = 8;

  typedef enum logic [3:0] {
    ADD    = 4'd0,
    ADC    = 4'd1,
    SUB    = 4'd2,
    SBB    = 4'd3,
    AND    = 4'd4,
    OR     = 4'd5,
    XOR    = 4'd6,
    NOT_A  = 4'd7,
    PASS_A = 4'd8
  } alu_pipe_op_t;

endpackage

// File: rtl/alu_pipe_exec.sv
// Combinational ALU: unsigned operands zero-extended one bit; MSB of the result is carry/borrow.
module alu_pipe_exec
  import ALU_REGFILE_defs::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  alu_pipe_op_t          op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cin,
  output logic [DATA_WIDTH:0]   res
);

  logic [DATA_WIDTH:0] ax, bx, cx;

  assign ax = {1'b0, a};
  assign bx = {1'b0, b};
  assign cx = {{DATA_WIDTH{1'b0}}, cin};

  // Subtraction wraps modulo 2^(DATA_WIDTH+1), so the MSB reads as borrow.
  always_comb begin
    res = '0;
    case (op)
      ADD:     res = ax + bx;
      ADC:     res = ax + bx + cx;
      SUB:     res = ax - bx;
      SBB:     res = ax - bx - cx;
      AND:     res = ax & bx;
      OR:      res = ax | bx;
      XOR:     res = ax ^ bx;
      NOT_A:   res = {1'b0, ~a};
      PASS_A:  res = ax;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu_regfile_pipe.sv
// Two-stage ALU pipeline over an internal register file with write-back and one-cycle forwarding.
// Optional ALU_PIPE_FLAGS_EN adds registered Zero_Flag / Neg_Flag outputs.
module alu_regfile_pipe
  import ALU_REGFILE_defs::*;
#(
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int REG_DEPTH  = REG_DEPTH_DEF,
  localparam int ADDR_WIDTH = $clog2(REG_DEPTH)
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  In_Valid,
  input  alu_pipe_op_t          Opcode,
  input  logic                  Carry_In,
  input  logic [ADDR_WIDTH-1:0] Read_Addr_1,
  input  logic [ADDR_WIDTH-1:0] Read_Addr_2,
  input  logic [ADDR_WIDTH-1:0] Dest_Addr,
  input  logic                  Wb_Enable,
  input  logic                  Write_enable,
  input  logic [ADDR_WIDTH-1:0] Write_Addr,
  input  logic [DATA_WIDTH-1:0] Write_data,
`ifdef ALU_PIPE_FLAGS_EN
  output logic                  Zero_Flag,
  output logic                  Neg_Flag,
`endif
  output logic [DATA_WIDTH:0]   ALU_Out,
  output logic                  Out_Valid,
  output logic [ADDR_WIDTH-1:0] Out_Dest
);

  localparam int STAGES = 1;

  logic [DATA_WIDTH-1:0] regs [REG_DEPTH];
  logic [STAGES:0]       vld_pipe;

  alu_pipe_op_t          r_op;
  logic                  r_cin;
  logic                  r_wb;
  logic [ADDR_WIDTH-1:0] r_dest;
  logic [DATA_WIDTH-1:0] r_a, r_b;

  logic [DATA_WIDTH:0]   exec_res;
  logic [DATA_WIDTH-1:0] opa, opb;
  logic                  fwd_hit, wb_fire;

  alu_pipe_exec #(.DATA_WIDTH(DATA_WIDTH)) u_exec (
    .op  (r_op),
    .a   (r_a),
    .b   (r_b),
    .cin (r_cin),
    .res (exec_res)
  );

  assign wb_fire = vld_pipe[0] && r_wb;
  assign fwd_hit = wb_fire;

  // Stage-R result bypasses the regfile for an issue in the very next cycle.
  always_comb begin
    opa = regs[Read_Addr_1];
    opb = regs[Read_Addr_2];
    if (fwd_hit && (Read_Addr_1 == r_dest)) opa = exec_res[DATA_WIDTH-1:0];
    if (fwd_hit && (Read_Addr_2 == r_dest)) opb = exec_res[DATA_WIDTH-1:0];
  end

  assign Out_Valid = vld_pipe[STAGES];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      vld_pipe <= '0;
      r_op     <= ADD;
      r_cin    <= 1'b0;
      r_wb     <= 1'b0;
      r_dest   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      ALU_Out  <= '0;
      Out_Dest <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], In_Valid};
      if (In_Valid) begin
        r_op   <= Opcode;
        r_cin  <= Carry_In;
        r_wb   <= Wb_Enable;
        r_dest <= Dest_Addr;
        r_a    <= opa;
        r_b    <= opb;
      end
      if (vld_pipe[0]) begin
        ALU_Out  <= exec_res;
        Out_Dest <= r_dest;
      end
    end
  end

  // Write-back is assigned last so it overrides an external load to the same entry.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
    end else begin
      if (Write_enable) regs[Write_Addr] <= Write_data;
      if (wb_fire)      regs[r_dest]     <= exec_res[DATA_WIDTH-1:0];
    end
  end

`ifdef ALU_PIPE_FLAGS_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Zero_Flag <= 1'b0;
      Neg_Flag  <= 1'b0;
    end else if (vld_pipe[0]) begin
      Zero_Flag <= (exec_res[DATA_WIDTH-1:0] == '0);
      Neg_Flag  <= exec_res[DATA_WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_alu_regfile_pipe.sv
// Directed bench for alu_regfile_pipe: vector table plus forwarding, collision and reset sequences.
module tb_alu_regfile_pipe;
  import ALU_REGFILE_defs::*;

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic         In_Valid = 1'b0;
  alu_pipe_op_t Opcode = ADD;
  logic         Carry_In = 1'b0;
  logic [2:0]   Read_Addr_1 = '0, Read_Addr_2 = '0, Dest_Addr = '0;
  logic         Wb_Enable = 1'b0;
  logic         Write_enable = 1'b0;
  logic [2:0]   Write_Addr = '0;
  logic [15:0]  Write_data = '0;
  logic [16:0]  ALU_Out;
  logic         Out_Valid;
  logic [2:0]   Out_Dest;
`ifdef ALU_PIPE_FLAGS_EN
  logic         Zero_Flag, Neg_Flag;
`endif

  int checks = 0;
  int failures = 0;

  alu_regfile_pipe dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .In_Valid     (In_Valid),
    .Opcode       (Opcode),
    .Carry_In     (Carry_In),
    .Read_Addr_1  (Read_Addr_1),
    .Read_Addr_2  (Read_Addr_2),
    .Dest_Addr    (Dest_Addr),
    .Wb_Enable    (Wb_Enable),
    .Write_enable (Write_enable),
    .Write_Addr   (Write_Addr),
    .Write_data   (Write_data),
`ifdef ALU_PIPE_FLAGS_EN
    .Zero_Flag    (Zero_Flag),
    .Neg_Flag     (Neg_Flag),
`endif
    .ALU_Out      (ALU_Out),
    .Out_Valid    (Out_Valid),
    .Out_Dest     (Out_Dest)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    alu_pipe_op_t op;
    logic         cin;
    logic [2:0]   ra1, ra2, dest;
    logic         wb;
    logic [16:0]  exp;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic issue(input alu_pipe_op_t op, input logic cin, input logic [2:0] a1,
                       input logic [2:0] a2, input logic [2:0] d, input logic wb);
    In_Valid = 1'b1; Opcode = op; Carry_In = cin;
    Read_Addr_1 = a1; Read_Addr_2 = a2; Dest_Addr = d; Wb_Enable = wb;
  endtask

  task automatic load(input logic [2:0] a, input logic [15:0] d);
    Write_enable = 1'b1; Write_Addr = a; Write_data = d;
    @(negedge Clock);
    Write_enable = 1'b0;
  endtask

  // Issue at the current falling edge; result is checked two falling edges later.
  task automatic run_op(input string name, input alu_pipe_op_t op, input logic cin,
                        input logic [2:0] a1, input logic [2:0] a2, input logic [2:0] d,
                        input logic wb, input logic [16:0] exp);
    issue(op, cin, a1, a2, d, wb);
    @(negedge Clock);
    In_Valid = 1'b0; Wb_Enable = 1'b0;
    @(negedge Clock);
    chk({name, "_valid"}, 32'(Out_Valid), 32'd1);
    chk({name, "_out"}, 32'(ALU_Out), 32'(exp));
    chk({name, "_dest"}, 32'(Out_Dest), 32'(d));
  endtask

  initial begin
    vecs[0]  = '{ADD,    1'b0, 3'd1, 3'd2, 3'd3, 1'b1, 17'h00008};
    vecs[1]  = '{PASS_A, 1'b0, 3'd3, 3'd0, 3'd1, 1'b0, 17'h00008};
    vecs[2]  = '{SUB,    1'b0, 3'd2, 3'd1, 3'd2, 1'b0, 17'h1FFFE};
    vecs[3]  = '{ADC,    1'b1, 3'd6, 3'd7, 3'd5, 1'b0, 17'h10001};
    vecs[4]  = '{ADD,    1'b1, 3'd6, 3'd7, 3'd4, 1'b0, 17'h10000};
    vecs[5]  = '{SBB,    1'b1, 3'd1, 3'd2, 3'd6, 1'b0, 17'h00001};
    vecs[6]  = '{SBB,    1'b1, 3'd0, 3'd0, 3'd7, 1'b0, 17'h1FFFF};
    vecs[7]  = '{AND,    1'b0, 3'd1, 3'd2, 3'd0, 1'b0, 17'h00001};
    vecs[8]  = '{OR,     1'b0, 3'd1, 3'd2, 3'd1, 1'b0, 17'h00007};
    vecs[9]  = '{XOR,    1'b0, 3'd1, 3'd2, 3'd2, 1'b0, 17'h00006};
    vecs[10] = '{NOT_A,  1'b0, 3'd1, 3'd2, 3'd3, 1'b0, 17'h0FFFA};
    vecs[11] = '{PASS_A, 1'b0, 3'd6, 3'd1, 3'd4, 1'b0, 17'h0FFFF};
    vecs[12] = '{SUB,    1'b1, 3'd1, 3'd2, 3'd5, 1'b0, 17'h00002};
    vecs[13] = '{SUB,    1'b0, 3'd1, 3'd1, 3'd6, 1'b0, 17'h00000};

    // Reset state
    repeat (2) @(negedge Clock);
    chk("rst_valid", 32'(Out_Valid), 32'd0);
    chk("rst_out",   32'(ALU_Out),   32'd0);
    chk("rst_dest",  32'(Out_Dest),  32'd0);
`ifdef ALU_PIPE_FLAGS_EN
    chk("rst_zero", 32'(Zero_Flag), 32'd0);
    chk("rst_neg",  32'(Neg_Flag),  32'd0);
`endif
    Reset = 1'b0;
    @(negedge Clock);
    load(3'd1, 16'h0005);
    load(3'd2, 16'h0003);

    // Back-to-back dependency uses the forwarded stage-R result
    issue(ADD, 1'b0, 3'd1, 3'd2, 3'd3, 1'b1);
    @(negedge Clock);
    issue(ADD, 1'b0, 3'd3, 3'd3, 3'd4, 1'b1);
    @(negedge Clock);
    In_Valid = 1'b0; Wb_Enable = 1'b0;
    chk("b2b_first_valid", 32'(Out_Valid), 32'd1);
    chk("b2b_first_out",   32'(ALU_Out),   32'h00008);
    @(negedge Clock);
    chk("b2b_second_valid", 32'(Out_Valid), 32'd1);
    chk("b2b_second_out",   32'(ALU_Out),   32'h00010);
    chk("b2b_second_dest",  32'(Out_Dest),  32'd4);
    // Dest equal to source reads the old value, then the next issue forwards it
    issue(ADD, 1'b0, 3'd4, 3'd4, 3'd4, 1'b1);
    @(negedge Clock);
    issue(PASS_A, 1'b0, 3'd4, 3'd0, 3'd2, 1'b0);
    @(negedge Clock);
    In_Valid = 1'b0;
    chk("self_dest_out", 32'(ALU_Out), 32'h00020);
    @(negedge Clock);
    chk("fwd_pass_out", 32'(ALU_Out), 32'h00020);
    @(negedge Clock);
    chk("bubble_valid", 32'(Out_Valid), 32'd0);
    chk("bubble_hold",  32'(ALU_Out),   32'h00020);

    // Same-edge write-back and external load to R5: write-back wins
    issue(ADD, 1'b0, 3'd1, 3'd2, 3'd5, 1'b1);
    @(negedge Clock);
    In_Valid = 1'b0; Wb_Enable = 1'b0;
    Write_enable = 1'b1; Write_Addr = 3'd5; Write_data = 16'h1234;
    @(negedge Clock);
    Write_enable = 1'b0;
    chk("coll_out", 32'(ALU_Out), 32'h00008);
    run_op("coll_r5", PASS_A, 1'b0, 3'd5, 3'd0, 3'd0, 1'b0, 17'h00008);
    // External write is not bypassed to a same-cycle read
    Write_enable = 1'b1; Write_Addr = 3'd5; Write_data = 16'h1234;
    issue(PASS_A, 1'b0, 3'd5, 3'd0, 3'd1, 1'b0);
    @(negedge Clock);
    Write_enable = 1'b0; In_Valid = 1'b0;
    @(negedge Clock);
    chk("nobypass_out", 32'(ALU_Out), 32'h00008);
    run_op("ext_r5", PASS_A, 1'b0, 3'd5, 3'd0, 3'd2, 1'b0, 17'h01234);

    // Vector table
    load(3'd6, 16'hFFFF);
    load(3'd7, 16'h0001);
    for (int i = 0; i < 14; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].cin, vecs[i].ra1, vecs[i].ra2,
             vecs[i].dest, vecs[i].wb, vecs[i].exp);
      @(negedge Clock);
      chk($sformatf("vec%0d_bubble", i), 32'(Out_Valid), 32'd0);
      chk($sformatf("vec%0d_hold", i), 32'(ALU_Out), 32'(vecs[i].exp));
    end

`ifdef ALU_PIPE_FLAGS_EN
    run_op("flag_xor", XOR, 1'b0, 3'd1, 3'd1, 3'd0, 1'b0, 17'h00000);
    chk("flag_xor_zero", 32'(Zero_Flag), 32'd1);
    chk("flag_xor_neg",  32'(Neg_Flag),  32'd0);
    run_op("flag_not", NOT_A, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 17'h0FFFF);
    chk("flag_not_zero", 32'(Zero_Flag), 32'd0);
    chk("flag_not_neg",  32'(Neg_Flag),  32'd1);
    @(negedge Clock);
    chk("flag_hold_neg", 32'(Neg_Flag), 32'd1);
`endif

    // Reset mid-cycle with ops in both stages
    issue(ADD, 1'b0, 3'd1, 3'd2, 3'd6, 1'b1);
    @(negedge Clock);
    issue(ADD, 1'b0, 3'd1, 3'd1, 3'd7, 1'b1);
    @(posedge Clock);
    #1;
    chk("inflight_valid", 32'(Out_Valid), 32'd1);
    chk("inflight_out",   32'(ALU_Out),   32'h00008);
    #1;
    Reset = 1'b1; In_Valid = 1'b0; Wb_Enable = 1'b0;
    #1;
    chk("midrst_valid", 32'(Out_Valid), 32'd0);
    chk("midrst_out",   32'(ALU_Out),   32'd0);
    chk("midrst_dest",  32'(Out_Dest),  32'd0);
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    run_op("post_r6", PASS_A, 1'b0, 3'd6, 3'd0, 3'd0, 1'b0, 17'h00000);
    run_op("post_r7", PASS_A, 1'b0, 3'd7, 3'd0, 3'd0, 1'b0, 17'h00000);
    run_op("post_r1", PASS_A, 1'b0, 3'd1, 3'd0, 3'd0, 1'b0, 17'h00000);
    load(3'd1, 16'h0005);
    load(3'd2, 16'h0003);
    run_op("post_add", ADD, 1'b0, 3'd1, 3'd2, 3'd3, 1'b1, 17'h00008);
    run_op("post_r3", PASS_A, 1'b0, 3'd3, 3'd0, 3'd1, 1'b0, 17'h00008);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
